// File: rtl/settings_pkg.sv
// Shared types and constants for the settings menu sequencer.
//   seq_state_t  : sequencer states EDIT / COUNTDOWN / LOCKED
//   ROW_*        : menu row indices for hovered_idx
//   *_MIN/*_MAX  : saturation limits of the editable fields
//   step_field() : one saturating +1/-1 step of a field value
package settings_pkg;

  typedef enum logic [1:0] {EDIT, COUNTDOWN, LOCKED} seq_state_t;

  localparam logic [2:0] ROW_DIFF  = 3'd0;
  localparam logic [2:0] ROW_LIVES = 3'd1;
  localparam logic [2:0] ROW_SPEED = 3'd2;
  localparam logic [2:0] ROW_START = 3'd3;

  localparam logic [2:0] DIFF_MIN  = 3'd0;
  localparam logic [2:0] DIFF_MAX  = 3'd2;
  localparam logic [2:0] LIVES_MIN = 3'd1;
  localparam logic [2:0] LIVES_MAX = 3'd5;
  localparam logic [2:0] SPEED_MIN = 3'd0;
  localparam logic [2:0] SPEED_MAX = 3'd3;

  // Saturating step; inc and dec are never both set by the caller.
  function automatic logic [2:0] step_field(input logic [2:0] val, input logic [2:0] lo,
                                            input logic [2:0] hi, input logic inc,
                                            input logic dec);
    logic [2:0] res;
    res = val;
    if (inc && (val < hi)) res = val + 3'd1;
    else if (dec && (val > lo)) res = val - 3'd1;
    return res;
  endfunction

endpackage

// File: rtl/settings_config_sequencer_if.sv
// Menu-side bus of the settings sequencer.
//   master : menu/keypad/video side (drives inputs, reads configuration)
//   slave  : settings_config_sequencer
interface settings_config_sequencer_if;
  logic [9:0] key_is_pressed;
  logic       enter;
  logic [2:0] hovered_idx;
  logic       start_of_frame;
  logic [1:0] difficulty;
  logic [2:0] lives;
  logic [1:0] ghost_speed;
  logic       countdown_active;
  logic [1:0] countdown_val;
  logic       game_start;
  logic       settings_locked;

  modport master (
    output key_is_pressed, enter, hovered_idx, start_of_frame,
    input  difficulty, lives, ghost_speed, countdown_active, countdown_val,
           game_start, settings_locked
  );

  modport slave (
    input  key_is_pressed, enter, hovered_idx, start_of_frame,
    output difficulty, lives, ghost_speed, countdown_active, countdown_val,
           game_start, settings_locked
  );
endinterface

// File: rtl/key_autorepeat.sv
// Edge detect and optional hold-to-repeat for one direction key.
//   clk, reset : clock, async active-high reset
//   key        : level of this key
//   other      : level of the opposite key (both held = no stepping)
//   tick       : start_of_frame pulse
//   clear      : restart repeat timing (not in EDIT or hovered row changed)
//   step_c     : combinational one-cycle step request
// Repeat logic exists only with SETTINGS_AUTOREPEAT_EN defined.
module key_autorepeat #(
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  input  logic other,
  input  logic tick,
  input  logic clear,
  output logic step_c
);

  logic prev;
  logic edge_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= key;
  end

  assign edge_c = key & ~prev & ~other;

`ifdef SETTINGS_AUTOREPEAT_EN
  localparam int unsigned MAX_V = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW    = $clog2(MAX_V + 1);

  logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
  logic          rep_q, rep_n;
  logic          rpt_c;

  // Ticks since hold start (first step at DELAY), then since last step (RATE).
  always_comb begin
    cnt_n   = cnt_q;
    rep_n   = rep_q;
    rpt_c   = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    if (!key || other || clear) begin
      cnt_n = '0;
      rep_n = 1'b0;
    end else if (tick) begin
      if (cnt_inc == (rep_q ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY))) begin
        rpt_c = 1'b1;
        cnt_n = '0;
        rep_n = 1'b1;
      end else begin
        cnt_n = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      rep_q <= rep_n;
    end
  end

  assign step_c = edge_c | rpt_c;
`else
  logic        unused_inputs;
  logic [31:0] unused_cfg;
  assign unused_inputs = ^{tick, clear};
  assign unused_cfg    = REPEAT_DELAY ^ REPEAT_RATE;
  assign step_c        = edge_c;
`endif

endmodule

// File: rtl/settings_config_sequencer.sv
// Settings menu sequencer: edits difficulty/lives/ghost speed, runs a
// frame-timed 3-2-1 countdown on START, then pulses game_start and locks.
//   clk, reset : clock, async active-high reset
//   bus        : settings_config_sequencer_if.slave (keys, enter, row,
//                frame tick in; settings and countdown status out)
// Optional hold-to-repeat on left/right: define SETTINGS_AUTOREPEAT_EN.
module settings_config_sequencer
  import settings_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_RATE     = 6,
  parameter int unsigned LIVES_DEFAULT   = 3
) (
  input logic                        clk,
  input logic                        reset,
  settings_config_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  seq_state_t       state, state_n;
  logic [1:0]       diff_q, diff_n, speed_q, speed_n, cd_val_q, cd_val_n;
  logic [2:0]       lives_q, lives_n;
  logic [CNT_W-1:0] frame_q, frame_n;
  logic             game_start_q, game_start_n;
  logic             active_q, locked_q;
  logic             enter_prev, enter_press;
  logic             left_key, right_key, left_step, right_step, rpt_clear;
  logic             tick;
  logic             unused_keys;

  assign left_key    = bus.key_is_pressed[4];
  assign right_key   = bus.key_is_pressed[6];
  assign tick        = bus.start_of_frame;
  assign enter_press = bus.enter & ~enter_prev;
  assign unused_keys = ^{bus.key_is_pressed[9:7], bus.key_is_pressed[5], bus.key_is_pressed[3:0]};

`ifdef SETTINGS_AUTOREPEAT_EN
  logic [2:0] hov_prev;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hov_prev <= 3'd0;
    else       hov_prev <= bus.hovered_idx;
  end
  assign rpt_clear = (state != EDIT) | (bus.hovered_idx != hov_prev);
`else
  assign rpt_clear = (state != EDIT);
`endif

  key_autorepeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_left (
    .clk(clk), .reset(reset), .key(left_key), .other(right_key),
    .tick(tick), .clear(rpt_clear), .step_c(left_step)
  );

  key_autorepeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_right (
    .clk(clk), .reset(reset), .key(right_key), .other(left_key),
    .tick(tick), .clear(rpt_clear), .step_c(right_step)
  );

  // Next-state, field edits and countdown timing.
  always_comb begin
    state_n      = state;
    diff_n       = diff_q;
    lives_n      = lives_q;
    speed_n      = speed_q;
    cd_val_n     = cd_val_q;
    frame_n      = frame_q;
    game_start_n = 1'b0;
    case (state)
      EDIT: begin
        if (bus.hovered_idx == ROW_DIFF)
          diff_n = 2'(step_field(3'(diff_q), DIFF_MIN, DIFF_MAX, right_step, left_step));
        if (bus.hovered_idx == ROW_LIVES)
          lives_n = step_field(lives_q, LIVES_MIN, LIVES_MAX, right_step, left_step);
        if (bus.hovered_idx == ROW_SPEED)
          speed_n = 2'(step_field(3'(speed_q), SPEED_MIN, SPEED_MAX, right_step, left_step));
        if (enter_press && (bus.hovered_idx == ROW_START)) begin
          state_n  = COUNTDOWN;
          cd_val_n = 2'd3;
          frame_n  = '0;
        end
      end
      COUNTDOWN: begin
        // Abort takes priority over a coincident frame tick.
        if (enter_press) begin
          state_n  = EDIT;
          cd_val_n = 2'd0;
          frame_n  = '0;
        end else if (tick) begin
          if (frame_q == CNT_W'(FRAMES_PER_STEP - 1)) begin
            frame_n = '0;
            if (cd_val_q == 2'd1) begin
              state_n      = LOCKED;
              cd_val_n     = 2'd0;
              game_start_n = 1'b1;
            end else begin
              cd_val_n = cd_val_q - 2'd1;
            end
          end else begin
            frame_n = frame_q + CNT_W'(1);
          end
        end
      end
      LOCKED: begin
      end
      default: state_n = EDIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EDIT;
      diff_q       <= 2'd1;
      lives_q      <= 3'(LIVES_DEFAULT);
      speed_q      <= 2'd1;
      cd_val_q     <= 2'd0;
      frame_q      <= '0;
      game_start_q <= 1'b0;
      active_q     <= 1'b0;
      locked_q     <= 1'b0;
      enter_prev   <= 1'b0;
    end else begin
      state        <= state_n;
      diff_q       <= diff_n;
      lives_q      <= lives_n;
      speed_q      <= speed_n;
      cd_val_q     <= cd_val_n;
      frame_q      <= frame_n;
      game_start_q <= game_start_n;
      active_q     <= (state_n == COUNTDOWN);
      locked_q     <= (state_n == LOCKED);
      enter_prev   <= bus.enter;
    end
  end

  assign bus.difficulty       = diff_q;
  assign bus.lives            = lives_q;
  assign bus.ghost_speed      = speed_q;
  assign bus.countdown_active = active_q;
  assign bus.countdown_val    = cd_val_q;
  assign bus.game_start       = game_start_q;
  assign bus.settings_locked  = locked_q;

endmodule

// File: tb/tb_settings_config_sequencer.sv
// Self-checking bench for settings_config_sequencer with a rule-level model.
module tb_settings_config_sequencer;

  localparam int FPS = 4;
  localparam int RD  = 2;
  localparam int RR  = 1;
  localparam int LD  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       drv_l = 1'b0, drv_r = 1'b0, drv_e = 1'b0, drv_t = 1'b0;
  logic [2:0] drv_h = 3'd0;

  settings_config_sequencer_if bus_if ();

  assign bus_if.key_is_pressed = {3'b000, drv_r, 1'b0, drv_l, 4'b0000};
  assign bus_if.enter          = drv_e;
  assign bus_if.hovered_idx    = drv_h;
  assign bus_if.start_of_frame = drv_t;

  settings_config_sequencer #(
    .FRAMES_PER_STEP(FPS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .LIVES_DEFAULT(LD)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if)
  );

  int passed = 0;
  int total  = 0;
  int gs_count = 0;
  bit chk_en = 1'b0;

  // Model: 0 = edit, 1 = countdown, 2 = locked
  int m_state, m_diff, m_lives, m_speed, m_cd, m_frames, m_gs;
  int m_prev_l, m_prev_r, m_prev_e, m_hov_prev;
  int m_held_l, m_held_r;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic bit rep_hit(input int held);
    return (held == RD) || ((held > RD) && (((held - RD) % RR) == 0));
  endfunction

  task automatic model_reset();
    m_state = 0; m_diff = 1; m_lives = LD; m_speed = 1; m_cd = 0; m_frames = 0; m_gs = 0;
    m_prev_l = 0; m_prev_r = 0; m_prev_e = 0; m_hov_prev = 0; m_held_l = 0; m_held_r = 0;
  endtask

  // Applies the rules for one clock edge using the inputs present at that edge.
  task automatic model_clock();
    int l, r, e, h, t, step_l, step_r, delta;
    bit rep_l, rep_r, hov_chg;
    if (reset) begin
      model_reset();
      return;
    end
    l = int'(drv_l); r = int'(drv_r); e = int'(drv_e); h = int'(drv_h); t = int'(drv_t);
    m_gs = 0;
    rep_l = 1'b0; rep_r = 1'b0;
    hov_chg = (h != m_hov_prev);
`ifdef SETTINGS_AUTOREPEAT_EN
    if (m_state != 0 || l == 0 || r == 1 || hov_chg) m_held_l = 0;
    else if (t == 1) begin m_held_l++; rep_l = rep_hit(m_held_l); end
    if (m_state != 0 || r == 0 || l == 1 || hov_chg) m_held_r = 0;
    else if (t == 1) begin m_held_r++; rep_r = rep_hit(m_held_r); end
`endif
    step_l = ((l == 1 && m_prev_l == 0 && r == 0) || rep_l) ? 1 : 0;
    step_r = ((r == 1 && m_prev_r == 0 && l == 0) || rep_r) ? 1 : 0;
    delta = step_r - step_l;
    case (m_state)
      0: begin
        if (h == 0) m_diff  = clamp(m_diff + delta, 0, 2);
        if (h == 1) m_lives = clamp(m_lives + delta, 1, 5);
        if (h == 2) m_speed = clamp(m_speed + delta, 0, 3);
        if (e == 1 && m_prev_e == 0 && h == 3) begin
          m_state = 1; m_cd = 3; m_frames = 0;
        end
      end
      1: begin
        if (e == 1 && m_prev_e == 0) begin
          m_state = 0; m_cd = 0; m_frames = 0;
        end else if (t == 1) begin
          m_frames++;
          if (m_frames == FPS) begin
            m_frames = 0;
            if (m_cd == 1) begin m_state = 2; m_cd = 0; m_gs = 1; end
            else m_cd--;
          end
        end
      end
      default: ;
    endcase
    m_prev_l = l; m_prev_r = r; m_prev_e = e; m_hov_prev = h;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("difficulty", int'(bus_if.difficulty), m_diff);
      check("lives", int'(bus_if.lives), m_lives);
      check("ghost_speed", int'(bus_if.ghost_speed), m_speed);
      check("countdown_active", int'(bus_if.countdown_active), (m_state == 1) ? 1 : 0);
      check("countdown_val", int'(bus_if.countdown_val), m_cd);
      check("game_start", int'(bus_if.game_start), m_gs);
      check("settings_locked", int'(bus_if.settings_locked), (m_state == 2) ? 1 : 0);
      if (bus_if.game_start) gs_count++;
    end
  end

  // One clock with the given inputs; returns at posedge+3.
  task automatic cycle(input logic l, input logic r, input logic e, input logic [2:0] h,
                       input logic t);
    drv_l = l; drv_r = r; drv_e = e; drv_h = h; drv_t = t;
    @(posedge clk);
    #1;
    model_clock();
    #2;
  endtask

  task automatic idle(input logic [2:0] h, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, h, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_difficulty"}, int'(bus_if.difficulty), 1);
    check({tag, "_lives"}, int'(bus_if.lives), 3);
    check({tag, "_speed"}, int'(bus_if.ghost_speed), 1);
    check({tag, "_active"}, int'(bus_if.countdown_active), 0);
    check({tag, "_cd_val"}, int'(bus_if.countdown_val), 0);
    check({tag, "_game_start"}, int'(bus_if.game_start), 0);
    check({tag, "_locked"}, int'(bus_if.settings_locked), 0);
  endtask

  int exp_up[6]   = '{4, 5, 5, 5, 5, 5};
  int exp_down[6] = '{4, 3, 2, 1, 1, 1};
  int exp_cd[12]  = '{3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0};
  int exp_rep[5]  = '{1, 2, 2, 2, 2};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    chk_en = 1'b1;
    check_reset_values("reset");
    idle(3'd0, 3);
    check_reset_values("idle");

    // Lives up to saturation, then down to the floor.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
      check($sformatf("lives_up%0d", i), int'(bus_if.lives), exp_up[i]);
      cycle(1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
      check($sformatf("lives_down%0d", i), int'(bus_if.lives), exp_down[i]);
      cycle(1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    end

    // Both keys together, ignored rows, other fields.
    cycle(1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
    check("both_keys", int'(bus_if.lives), 1);
    idle(3'd1, 1);
    cycle(1'b0, 1'b1, 1'b0, 3'd5, 1'b0);
    check("row5_ignored", int'(bus_if.difficulty) + int'(bus_if.lives) + int'(bus_if.ghost_speed), 3);
    idle(3'd5, 1);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    check("diff_dec", int'(bus_if.difficulty), 0);
    idle(3'd0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
      idle(3'd2, 1);
    end
    check("speed_sat", int'(bus_if.ghost_speed), 3);
    idle(3'd3, 2);

    // Full countdown into LOCKED.
    cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    check("cd_start_val", int'(bus_if.countdown_val), 3);
    check("cd_start_active", int'(bus_if.countdown_active), 1);
    cycle(1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
      check($sformatf("cd_tick%0d", i + 1), int'(bus_if.countdown_val), exp_cd[i]);
      if (i == 11) check("gs_pulse", int'(bus_if.game_start), 1);
      cycle(1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
    end
    check("locked", int'(bus_if.settings_locked), 1);
    check("gs_cleared", int'(bus_if.game_start), 0);
    cycle(1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b1);
    idle(3'd3, 2);
    check("locked_lives", int'(bus_if.lives), 1);
    check("gs_count", gs_count, 1);

    // Asynchronous reset between edges.
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("async_rst");
    #2;
    idle(3'd0, 2);
    reset = 1'b0;
    idle(3'd3, 2);

    // Abort coincident with a tick while countdown_val == 2.
    cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 3'd3, 1'b1);
    check("abort_pre_val", int'(bus_if.countdown_val), 2);
    cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b1);
    check("abort_val", int'(bus_if.countdown_val), 0);
    check("abort_active", int'(bus_if.countdown_active), 0);
    idle(3'd3, 3);
    check("abort_no_gs", gs_count, 1);
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    check("post_abort_diff", int'(bus_if.difficulty), 2);
    idle(3'd0, 2);

`ifdef SETTINGS_AUTOREPEAT_EN
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(3'd0, 1);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(3'd0, 1);
    check("rep_start", int'(bus_if.difficulty), 0);
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    check("rep_edge", int'(bus_if.difficulty), 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
      check($sformatf("rep_tick%0d", i + 1), int'(bus_if.difficulty), exp_rep[i]);
      cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    end
    idle(3'd0, 2);
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/settings_config_sequencer.md
Name: settings_config_sequencer

Overview:
- Sits behind the settings menu. It consumes the menu's hovered row index plus keypad and enter inputs.
- Edits three game settings: difficulty, lives and ghost speed.
- When START is confirmed, runs a frame-timed 3-2-1 countdown, then emits a one-cycle game_start pulse and freezes the settings.
- Outputs feed the game core configuration inputs and the countdown text generator.

Parameters:
- FRAMES_PER_STEP, 60: start_of_frame ticks per countdown step.
- REPEAT_DELAY, 20: frames a left/right key must be held before auto-repeat begins.
- REPEAT_RATE, 6: frames between auto-repeat steps.
- LIVES_DEFAULT, 3: lives value after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_is_pressed  in  10  keypad level vector; bit4 = left, bit6 = right.
- enter  in  1  enter key level.
- hovered_idx  in  3  menu row: 0 difficulty, 1 lives, 2 speed, 3 START; values 4..7 are ignored.
- start_of_frame  in  1  one-cycle pulse per video frame.
- difficulty  out  2  0..2.
- lives  out  3  1..5.
- ghost_speed  out  2  0..3.
- countdown_active  out  1  high in COUNTDOWN.
- countdown_val  out  2  3, 2 or 1 while counting; 0 otherwise.
- game_start  out  1  one-cycle pulse on countdown expiry.
- settings_locked  out  1  high in LOCKED.

Behaviour:
- Reset values:
  - difficulty = 1, lives = LIVES_DEFAULT, ghost_speed = 1.
  - countdown_active = 0, countdown_val = 0, game_start = 0, settings_locked = 0.
  - State = EDIT; all delay registers and counters = 0.
  - Reset mid-countdown or in LOCKED returns to exactly these values.
- Edge detect: left, right and enter are registered once. A press is level & ~previous.
- State EDIT:
  - A left press decrements the field selected by hovered_idx; a right press increments it.
  - Fields saturate and never wrap: difficulty 0..2, lives 1..5, ghost_speed 0..3.
  - Left and right asserted in the same cycle means no change.
  - hovered_idx 3..7 means no field change.
  - Updated value is visible 1 cycle after the edge cycle.
  - Enter press with hovered_idx == 3 goes to COUNTDOWN: countdown_val = 3, frame counter = 0, countdown_active = 1 from the next cycle.
- State COUNTDOWN:
  - Settings are frozen; left and right are ignored.
  - Each start_of_frame increments the frame counter.
  - When the counter reaches FRAMES_PER_STEP-1 on a tick, the counter clears and countdown_val decrements.
  - When the decrement would go from 1 to 0: go to LOCKED and assert game_start for exactly that next cycle.
  - countdown_val = 0 and countdown_active = 0 in the same cycle that game_start is asserted.
  - Enter press aborts: return to EDIT, countdown_val = 0, no game_start.
  - A tick and enter in the same cycle: abort wins.
- State LOCKED:
  - settings_locked = 1. All inputs are ignored until reset.
  - game_start is never reasserted.
- Counter widths: frame counter is $clog2(FRAMES_PER_STEP) bits, or wider; no overflow is allowed.

Optional Feature:
- Macro: SETTINGS_AUTOREPEAT_EN.
- Enabled:
  - In EDIT, a left or right key held alone counts start_of_frame ticks.
  - After REPEAT_DELAY ticks, one step is applied. Then one step is applied every REPEAT_RATE ticks while the key stays held.
  - Saturation rules still apply.
  - Releasing the key, pressing both keys, a change of hovered_idx, or leaving EDIT clears the repeat counter.
- Disabled: edge-only stepping; no repeat counter is synthesised.

Decomposition:
- Shared package settings_pkg holds:
  - enum seq_state_t {EDIT, COUNTDOWN, LOCKED};
  - row index constants ROW_DIFF = 0, ROW_LIVES = 1, ROW_SPEED = 2, ROW_START = 3;
  - field min/max constants.
- One natural sub-module, key_autorepeat: edge detect plus the repeat counter for one key, instantiated for left and right. Its repeat logic is inside the macro guard.

Test Plan:
- Reset then idle -> difficulty = 1, lives = 3, ghost_speed = 1, all other outputs 0, state EDIT.
- hovered_idx = 1, six right presses -> lives 4, 5, 5, 5, 5, 5. Then six left presses -> lives ends at 1, never 0.
- hovered_idx = 3, enter press, FRAMES_PER_STEP = 4, 12 frame ticks:
  - countdown_val goes 3 -> 2 -> 1 after ticks 4 and 8;
  - game_start is a single pulse after tick 12;
  - settings_locked = 1; countdown_val = 0.
- Mid-countdown (countdown_val = 2), enter press coincident with a tick -> back to EDIT, countdown_val = 0, no game_start. Right press then changes the selected field.
- LOCKED, then reset asserted asynchronously between clock edges -> all outputs return to reset values immediately; settings_locked drops to 0.
- With SETTINGS_AUTOREPEAT_EN, REPEAT_DELAY = 2, REPEAT_RATE = 1, hovered_idx = 0 from difficulty 0, right held for 5 ticks -> difficulty 1 (edge), 2 at tick 2, stays 2 (saturated).
